ahb_lite_req_arbiter: RTL

Two-port request arbiter and transfer sequencer placed in front of the AHB-Lite master top. It accepts single-beat read/write requests from two independent requesters over valid/ready handshakes and arbitrates between them, round-robin or fixed priority. The granted request drives the master's command inputs (write, addr, data, data_size, idle) for one non-pipelined address/data phase pair. The read data or error response is returned to the requester that owns the transfer.

---
 rtl/ahb_lite_req_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/ahb_lite_req_arbiter.sv
// ahb_lite_req_arbiter: two-requester valid/ready arbiter sequencing single non-pipelined AHB-Lite transfers
module ahb_lite_req_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [2:0]  req0_size,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [2:0]  req1_size,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        cmd_write,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic [2:0]  cmd_size,
  output logic        cmd_idle,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_n;
  logic last, own, pick, any, illegal, fire, done, sel_write, f_err;
  logic [31:0] sel_addr, sel_wdata, f_rdata;
  logic [2:0] sel_size;
  // RESP entered without a pending pulse means an illegal request: emit the error pulse one cycle later
  always_comb begin
    any = req0_valid | req1_valid;
    pick = (req0_valid & req1_valid) ? (FIXED_PRIORITY ? 1'b0 : ~last) : req1_valid;
    sel_write = pick ? req1_write : req0_write;
    sel_addr = pick ? req1_addr : req0_addr;
    sel_wdata = pick ? req1_wdata : req0_wdata;
    sel_size = pick ? req1_size : req0_size;
    illegal = (sel_size > 3'd2) | (sel_size == 3'd1 & sel_addr[0]) | (sel_size == 3'd2 & |sel_addr[1:0]);
    done = rsp0_valid | rsp1_valid;
    fire = (state == DATA & HREADY) | (state == RESP & ~done);
    f_err = (state == DATA) ? HRESP : 1'b1;
    f_rdata = (state == DATA & ~cmd_write & ~HRESP) ? HRDATA : 32'd0;
    state_n = (state == IDLE) ? (any ? (illegal ? RESP : ADDR) : IDLE) :
              (state == ADDR) ? (HREADY ? DATA : ADDR) :
              (state == DATA) ? (HREADY ? RESP : DATA) :
              (done ? IDLE : RESP);
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
      last <= 1'b1;
      own <= 1'b0;
      cmd_idle <= 1'b1;
      cmd_write <= 1'b0;
      cmd_addr <= 32'd0;
      cmd_data <= 32'd0;
      cmd_size <= 3'd0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= 32'd0;
      rsp1_rdata <= 32'd0;
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      state <= state_n;
      cmd_idle <= state_n != ADDR;
      req0_ready <= state == IDLE & any & ~pick;
      req1_ready <= state == IDLE & any & pick;
      rsp0_valid <= fire & ~own;
      rsp1_valid <= fire & own;
      if (state == IDLE & any) begin
        own <= pick;
        cmd_write <= sel_write;
        cmd_addr <= sel_addr;
        cmd_data <= sel_wdata;
        cmd_size <= sel_size;
      end
      if (fire & ~own) begin
        rsp0_rdata <= f_rdata;
        rsp0_err <= f_err;
      end
      if (fire & own) begin
        rsp1_rdata <= f_rdata;
        rsp1_err <= f_err;
      end
      if (state == RESP & done) last <= own;
    end
  end
endmodule
